// File: rtl/rd_ddr_queue_engine.sv
// Per-queue circular DDR reader: splits requests into 4 KB-safe AXI INCR bursts, one outstanding.
// Define RD_RESP_CHECK_EN to make o_rd_err a sticky flag for non-OKAY read responses.
module rd_ddr_queue_engine #(
    parameter int unsigned                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                          C_M_AXI_DATA_WIDTH = 512,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]        P_MAX_ADDR         = 'h003F_FFFF,
    parameter int unsigned                          P_QUEUE_NUM        = 8,
    parameter int unsigned                          P_BURST_LEN        = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_rd_flag,
    input  logic [2:0]                      i_rd_queue,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_rd_byte,
    input  logic                            i_rd_byte_valid,
    output logic                            o_rd_byte_ready,
    output logic                            o_rd_queue_finish,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   o_m_axi_araddr,
    output logic [7:0]                      o_m_axi_arlen,
    output logic [2:0]                      o_m_axi_arsize,
    output logic [1:0]                      o_m_axi_arburst,
    output logic                            o_m_axi_arvalid,
    input  logic                            i_m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_m_axi_rdata,
    input  logic [1:0]                      i_m_axi_rresp,
    input  logic                            i_m_axi_rlast,
    input  logic                            i_m_axi_rvalid,
    output logic                            o_m_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_data,
    output logic                            o_data_valid,
    output logic                            o_data_last,
    output logic [2:0]                      o_data_queue,
    output logic                            o_data_flag,
    input  logic                            i_data_ready,
    output logic                            o_rd_err
);
    localparam int unsigned   AW        = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned   BYTES     = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned   LG_B      = $clog2(BYTES);
    localparam logic [AW-1:0] REGION    = AW'(({1'b0, P_MAX_ADDR} + 1'b1) / P_QUEUE_NUM);
    localparam logic [AW-1:0] BURST_MAX = AW'(P_BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_DATA, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            flag_q, flag_d;
    logic [2:0]      queue_q, queue_d;
    logic [AW-1:0]   rem_q, rem_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [7:0]      arlen_q, arlen_d;
    logic [AW-1:0]   rd_ptr_q [P_QUEUE_NUM];

    logic [AW-1:0]   cur_ptr, region_base, req_beats, bnd_beats, burst, ptr_sum, ptr_next;
    logic [12:0]     to_4k;
    logic            ptr_we, beat_hs;

    assign cur_ptr     = rd_ptr_q[queue_q];
    assign region_base = AW'(queue_q) * REGION;
    assign req_beats   = (i_rd_byte >> LG_B) + AW'(|i_rd_byte[LG_B-1:0]);
    // Regions are 4 KB aligned, so the pointer's low 12 bits locate the next 4 KB boundary.
    assign to_4k       = 13'h1000 - {1'b0, cur_ptr[11:0]};
    assign bnd_beats   = AW'(to_4k >> LG_B);
    assign ptr_sum     = cur_ptr + (burst << LG_B);
    assign ptr_next    = (ptr_sum >= REGION) ? '0 : ptr_sum;
    assign beat_hs     = (state_q == S_DATA) && i_m_axi_rvalid && i_data_ready;

    always_comb begin
        burst = rem_q;
        if (burst > BURST_MAX) burst = BURST_MAX;
        if (burst > bnd_beats) burst = bnd_beats;
    end

    always_comb begin
        state_d  = state_q;
        flag_d   = flag_q;
        queue_d  = queue_q;
        rem_d    = rem_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        ptr_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rd_byte_valid && o_rd_byte_ready) begin
                    flag_d  = i_rd_flag;
                    queue_d = i_rd_queue;
                    rem_d   = req_beats;
                    state_d = (req_beats == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                araddr_d = region_base + cur_ptr;
                arlen_d  = 8'(burst - 1'b1);
                rem_d    = rem_q - burst;
                ptr_we   = 1'b1;
                state_d  = S_AR;
            end
            S_AR:   if (i_m_axi_arready) state_d = S_DATA;
            S_DATA: if (beat_hs && i_m_axi_rlast) state_d = (rem_q == '0) ? S_DONE : S_CALC;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            flag_q   <= 1'b0;
            queue_q  <= '0;
            rem_q    <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            for (int i = 0; i < int'(P_QUEUE_NUM); i++) rd_ptr_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            queue_q  <= queue_d;
            rem_q    <= rem_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            if (ptr_we) rd_ptr_q[queue_q] <= ptr_next;
        end
    end

    assign o_rd_byte_ready   = (state_q == S_IDLE) && !i_rst;
    assign o_rd_queue_finish = (state_q == S_DONE);
    assign o_m_axi_araddr    = araddr_q;
    assign o_m_axi_arlen     = arlen_q;
    assign o_m_axi_arsize    = 3'(LG_B);
    assign o_m_axi_arburst   = 2'b01;
    assign o_m_axi_arvalid   = (state_q == S_AR);
    assign o_m_axi_rready    = (state_q == S_DATA) && i_data_ready;
    assign o_data            = i_m_axi_rdata;
    assign o_data_valid      = (state_q == S_DATA) && i_m_axi_rvalid;
    // rem_q is already zero while the final burst streams.
    assign o_data_last       = o_data_valid && i_m_axi_rlast && (rem_q == '0);
    assign o_data_queue      = queue_q;
    assign o_data_flag       = flag_q;

`ifdef RD_RESP_CHECK_EN
    logic rd_err_q, rd_err_d;
    assign rd_err_d = rd_err_q | (beat_hs && (i_m_axi_rresp != 2'b00));
    always_ff @(posedge i_clk) begin
        if (i_rst) rd_err_q <= 1'b0;
        else       rd_err_q <= rd_err_d;
    end
    assign o_rd_err = rd_err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^i_m_axi_rresp;
    assign o_rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ddr_queue_engine.sv
// Scoreboard bench for rd_ddr_queue_engine: directed requests, AXI slave model, decoupled monitor.
module tb_rd_ddr_queue_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         rd_flag, rd_valid;
    logic [2:0]   rd_queue;
    logic [31:0]  rd_byte;
    logic         rd_ready, finish;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [511:0] odata;
    logic         dvalid, dlast, dflag, dready, rd_err;
    logic [2:0]   dqueue;

`ifdef RD_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    rd_ddr_queue_engine dut (
        .i_clk(clk), .i_rst(rst),
        .i_rd_flag(rd_flag), .i_rd_queue(rd_queue), .i_rd_byte(rd_byte),
        .i_rd_byte_valid(rd_valid), .o_rd_byte_ready(rd_ready), .o_rd_queue_finish(finish),
        .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize),
        .o_m_axi_arburst(arburst), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
        .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast),
        .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready),
        .o_data(odata), .o_data_valid(dvalid), .o_data_last(dlast),
        .o_data_queue(dqueue), .o_data_flag(dflag), .i_data_ready(dready), .o_rd_err(rd_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [511:0] data; logic last; logic [2:0] q; logic f; } dt_t;

    ar_t  ar_q[$];
    dt_t  d_q[$];
    ar_t  ea;
    dt_t  ed;
    int   vectors = 0;
    int   miscompares = 0;
    int   pending = 0;
    time  ref_time = 0;
    logic inj_err = 1'b0;

    function automatic logic [511:0] mk(input logic [31:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = a + 32'(i);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_ar(input logic [31:0] a, input logic [7:0] len, input logic fin,
                          input logic [2:0] q, input logic f);
        ar_t x;
        dt_t y;
        x.addr = a; x.len = len;
        ar_q.push_back(x);
        for (int b = 0; b <= int'(len); b++) begin
            y.data = mk(a + 32'(b) * 32'd64);
            y.last = fin && (b == int'(len));
            y.q = q; y.f = f;
            d_q.push_back(y);
        end
    endtask

    task automatic send(input logic f, input logic [2:0] q, input logic [31:0] nb);
        int n;
        @(negedge clk);
        rd_valid = 1'b1; rd_flag = f; rd_queue = q; rd_byte = nb;
        n = 0;
        while (!rd_ready && n < 5000) begin @(negedge clk); n++; end
        if (!rd_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: queue %0d never accepted", q);
            rd_valid = 1'b0;
            return;
        end
        chk("accept_while_busy", 512'(pending), 512'd0);
        if (nb == 0) ref_time = $time;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        pending++;
        @(negedge clk); chk("arvalid_calc", 512'(arvalid), 512'd0);
        @(negedge clk); chk("arvalid_ar", 512'(arvalid), 512'(nb != 0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pending != 0 || ar_q.size() != 0 || d_q.size() != 0) && n < 5000) begin
            @(negedge clk); n++;
        end
        chk("drain_pending", 512'(pending), 512'd0);
        chk("drain_queues", 512'(ar_q.size() + d_q.size()), 512'd0);
    endtask

    // AXI read slave: random arready delay and beat gaps, data derived from beat address.
    initial begin
        logic [31:0] s_addr;
        logic [7:0]  s_len;
        int          n;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin
                if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                arready = 1'b1; s_addr = araddr; s_len = arlen;
                @(posedge clk); #1;
                arready = 1'b0;
                for (int b = 0; b <= int'(s_len); b++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    rvalid = 1'b1;
                    rdata  = mk(s_addr + 32'(b) * 32'd64);
                    rlast  = (b == int'(s_len));
                    rresp  = inj_err ? 2'b10 : 2'b00;
                    n = 0;
                    @(negedge clk);
                    while (!rready && n < 1000) begin @(negedge clk); n++; end
                    @(posedge clk); #1;
                    if (rresp != 2'b00) inj_err = 1'b0;
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 dready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_ar: araddr %0h arlen %0d", araddr, arlen);
                end else begin
                    ea = ar_q.pop_front();
                    chk("araddr", 512'(araddr), 512'(ea.addr));
                    chk("arlen", 512'(arlen), 512'(ea.len));
                    chk("arsize_arburst", 512'({arsize, arburst}), 512'({3'd6, 2'b01}));
                end
            end
            if (dvalid && dready) begin
                if (d_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_beat: data %0h", odata[31:0]);
                end else begin
                    ed = d_q.pop_front();
                    chk("data", odata, ed.data);
                    chk("data_last", 512'(dlast), 512'(ed.last));
                    chk("data_queue", 512'(dqueue), 512'(ed.q));
                    chk("data_flag", 512'(dflag), 512'(ed.f));
                    if (dlast) ref_time = $time;
                end
            end
            if (finish) begin
                chk("finish_time", 512'($time), 512'(ref_time + 10));
                if (pending == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_finish: at time %0t", $time);
                end else pending--;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: pending %0d ar %0d beats %0d", pending, ar_q.size(), d_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rd_valid = 1'b0; rd_flag = 1'b0; rd_queue = '0; rd_byte = '0; dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outputs", 512'({rd_ready, finish, arvalid, rready, dvalid, dlast, dflag, dqueue, rd_err}),
                512'd0);
            chk("rst_araddr_arlen", 512'({araddr, arlen}), 512'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 512'(rd_ready), 512'd1);

        exp_ar(32'h0010_0000, 8'd1, 1'b1, 3'd2, 1'b1);
        send(1'b1, 3'd2, 32'd128);
        exp_ar(32'h0010_0080, 8'd0, 1'b1, 3'd2, 1'b0);
        send(1'b0, 3'd2, 32'd64);
        exp_ar(32'h0000_0000, 8'd63, 1'b0, 3'd0, 1'b1);
        exp_ar(32'h0000_1000, 8'd63, 1'b1, 3'd0, 1'b1);
        send(1'b1, 3'd0, 32'd8192);
        exp_ar(32'h0008_0000, 8'd62, 1'b1, 3'd1, 1'b0);
        send(1'b0, 3'd1, 32'd4032);
        exp_ar(32'h0008_0FC0, 8'd0, 1'b0, 3'd1, 1'b1);
        exp_ar(32'h0008_1000, 8'd2, 1'b1, 3'd1, 1'b1);
        send(1'b1, 3'd1, 32'd256);
        drain();

        send(1'b1, 3'd3, 32'd0);
        drain();
        exp_ar(32'h0018_0000, 8'd0, 1'b1, 3'd3, 1'b0);
        send(1'b0, 3'd3, 32'd64);

        exp_ar(32'h0020_0000, 8'd1, 1'b1, 3'd4, 1'b0);
        send(1'b0, 3'd4, 32'd100);
        exp_ar(32'h0020_0080, 8'd0, 1'b1, 3'd4, 1'b1);
        send(1'b1, 3'd4, 32'd1);

        for (int i = 0; i < 127; i++) begin
            exp_ar(32'h0038_0000 + 32'(i) * 32'h1000, 8'd63, 1'b1, 3'd7, 1'b0);
            send(1'b0, 3'd7, 32'd4096);
        end
        exp_ar(32'h003F_F000, 8'd62, 1'b1, 3'd7, 1'b0);
        send(1'b0, 3'd7, 32'd4032);
        exp_ar(32'h003F_FFC0, 8'd0, 1'b0, 3'd7, 1'b1);
        exp_ar(32'h0038_0000, 8'd0, 1'b1, 3'd7, 1'b1);
        send(1'b1, 3'd7, 32'd128);
        drain();

        chk("rd_err_clean", 512'(rd_err), 512'd0);
        inj_err = 1'b1;
        exp_ar(32'h0028_0000, 8'd0, 1'b1, 3'd5, 1'b0);
        send(1'b0, 3'd5, 32'd64);
        drain();
        chk("rd_err_set", 512'(rd_err), 512'(EXP_ERR));
        exp_ar(32'h0028_0040, 8'd0, 1'b1, 3'd5, 1'b1);
        send(1'b1, 3'd5, 32'd64);
        drain();
        chk("rd_err_sticky", 512'(rd_err), 512'(EXP_ERR));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
